// File: rtl/multicycle_control_if.sv
// rtl/multicycle_control_if.sv - control/datapath bundle for the multicycle controller
interface multicycle_control_if #(
  parameter int STATE_W = 4
);
  logic [5:0]         OP;
  logic [5:0]         Funct;
  logic               Zero_Flag;
  logic               pc_en;
  logic               IorD;
  logic               mem_wr;
  logic               IR_wr;
  logic               reg_dst;
  logic               mem2reg;
  logic               reg_wr;
  logic               alu_srcA;
  logic [1:0]         alu_srcB;
  logic [2:0]         Alucontrol;
  logic [1:0]         PC_src;
  logic               instr_done;
  logic               illegal;
  logic [STATE_W-1:0] state;

  // controller side
  modport master (
    input  OP, Funct, Zero_Flag,
    output pc_en, IorD, mem_wr, IR_wr, reg_dst, mem2reg, reg_wr,
           alu_srcA, alu_srcB, Alucontrol, PC_src, instr_done, illegal, state
  );

  // datapath side
  modport slave (
    output OP, Funct, Zero_Flag,
    input  pc_en, IorD, mem_wr, IR_wr, reg_dst, mem2reg, reg_wr,
           alu_srcA, alu_srcB, Alucontrol, PC_src, instr_done, illegal, state
  );
endinterface

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - Moore FSM sequencing a multicycle MIPS-subset datapath
module multicycle_control #(
  parameter int STATE_W = 4
) (
  input logic                 clk,
  input logic                 Res,
  multicycle_control_if.master bus
);
  typedef enum logic [3:0] {
    FETCH  = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMRD  = 4'd3,
    MEMWB  = 4'd4,  MEMWR  = 4'd5,  EXEC   = 4'd6,  ALUWB  = 4'd7,
    BRANCH = 4'd8,  ADDIEX = 4'd9,  ADDIWB = 4'd10, JUMP   = 4'd11
  } state_t;

  typedef struct packed {
    logic       pc_en;
    logic       IorD;
    logic       mem_wr;
    logic       IR_wr;
    logic       reg_dst;
    logic       mem2reg;
    logic       reg_wr;
    logic       alu_srcA;
    logic [1:0] alu_srcB;
    logic [2:0] Alucontrol;
    logic [1:0] PC_src;
    logic       instr_done;
    logic       branch;      // pc_en follows Zero_Flag in this state
  } ctl_t;

  localparam logic [5:0] OP_LW = 6'b100011, OP_SW = 6'b101011, OP_R = 6'b000000,
                         OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010;

  state_t st, st_nx;
  ctl_t   ctl;
  logic   op_legal;

  function automatic logic [2:0] alu_from_funct(input logic [5:0] f);
    case (f)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  // Outputs are a pure function of the state being entered; Funct is stable
  // from the end of FETCH onwards, so EXEC can register its ALU code on entry.
  function automatic ctl_t ctl_for(input state_t s, input logic [5:0] f);
    ctl_t c;
    c = '0;
    case (s)
      FETCH:  begin c.IR_wr = 1'b1; c.alu_srcB = 2'b01; c.Alucontrol = 3'b010; c.pc_en = 1'b1; end
      DECODE: begin c.alu_srcB = 2'b11; c.Alucontrol = 3'b010; end
      MEMADR: begin c.alu_srcA = 1'b1; c.alu_srcB = 2'b10; c.Alucontrol = 3'b010; end
      MEMRD:  c.IorD = 1'b1;
      MEMWB:  begin c.mem2reg = 1'b1; c.reg_wr = 1'b1; c.instr_done = 1'b1; end
      MEMWR:  begin c.IorD = 1'b1; c.mem_wr = 1'b1; c.instr_done = 1'b1; end
      EXEC:   begin c.alu_srcA = 1'b1; c.Alucontrol = alu_from_funct(f); end
      ALUWB:  begin c.reg_dst = 1'b1; c.reg_wr = 1'b1; c.instr_done = 1'b1; end
      BRANCH: begin
        c.alu_srcA = 1'b1; c.Alucontrol = 3'b110; c.PC_src = 2'b01;
        c.branch = 1'b1; c.instr_done = 1'b1;
      end
      ADDIEX: begin c.alu_srcA = 1'b1; c.alu_srcB = 2'b10; c.Alucontrol = 3'b010; end
      ADDIWB: begin c.reg_wr = 1'b1; c.instr_done = 1'b1; end
      JUMP:   begin c.PC_src = 2'b10; c.pc_en = 1'b1; c.instr_done = 1'b1; end
      default: c = '0;
    endcase
    return c;
  endfunction

  // Next-state selection; unused codes fall back to FETCH
  always_comb begin
    st_nx = FETCH;
    case (st)
      FETCH:  st_nx = DECODE;
      DECODE: begin
        case (bus.OP)
          OP_LW, OP_SW: st_nx = MEMADR;
          OP_R:         st_nx = EXEC;
          OP_BEQ:       st_nx = BRANCH;
          OP_ADDI:      st_nx = ADDIEX;
          OP_J:         st_nx = JUMP;
          default:      st_nx = FETCH;
        endcase
      end
      MEMADR: st_nx = (bus.OP == OP_LW) ? MEMRD : MEMWR;
      MEMRD:  st_nx = MEMWB;
      EXEC:   st_nx = ALUWB;
      ADDIEX: st_nx = ADDIWB;
      default: st_nx = FETCH;
    endcase
  end

  // Opcode legality, only meaningful while in DECODE
  always_comb begin
    op_legal = 1'b0;
    case (bus.OP)
      OP_LW, OP_SW, OP_R, OP_BEQ, OP_ADDI, OP_J: op_legal = 1'b1;
      default: op_legal = 1'b0;
    endcase
  end

  // State register with outputs registered alongside it
  always_ff @(posedge clk) begin
    if (Res) begin
      st  <= FETCH;
      ctl <= ctl_for(FETCH, bus.Funct);
    end else begin
      st  <= st_nx;
      ctl <= ctl_for(st_nx, bus.Funct);
    end
  end

  // Side-effecting strobes are held low while reset is asserted
  assign bus.pc_en      = ~Res & (ctl.pc_en | (ctl.branch & bus.Zero_Flag));
  assign bus.IR_wr      = ~Res & ctl.IR_wr;
  assign bus.mem_wr     = ~Res & ctl.mem_wr;
  assign bus.reg_wr     = ~Res & ctl.reg_wr;
  assign bus.instr_done = ~Res & ctl.instr_done;
  assign bus.illegal    = ~Res & (st == DECODE) & ~op_legal;
  assign bus.IorD       = ctl.IorD;
  assign bus.reg_dst    = ctl.reg_dst;
  assign bus.mem2reg    = ctl.mem2reg;
  assign bus.alu_srcA   = ctl.alu_srcA;
  assign bus.alu_srcB   = ctl.alu_srcB;
  assign bus.Alucontrol = ctl.Alucontrol;
  assign bus.PC_src     = ctl.PC_src;
  assign bus.state      = STATE_W'(st);
endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - directed self-checking bench for multicycle_control
module tb_multicycle_control;
  logic clk = 1'b0;
  logic Res = 1'b1;
  int   total = 0;
  int   passed = 0;

  multicycle_control_if #(.STATE_W(4)) bus ();

  multicycle_control #(.STATE_W(4)) dut (
    .clk (clk),
    .Res (Res),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // advance one clock and sample 2 time units after the edge
  task automatic step(input string tag, input logic [3:0] exp_state);
    @(posedge clk);
    #2;
    chk(tag, 32'(bus.state), 32'(exp_state));
  endtask

  initial begin
    bus.OP = 6'b000000;
    bus.Funct = 6'b000000;
    bus.Zero_Flag = 1'b0;

    // reset: FETCH loaded, strobes forced low
    step("rst_state", 4'd0);
    chk("rst_pc_en", 32'(bus.pc_en), 32'd0);
    chk("rst_ir_wr", 32'(bus.IR_wr), 32'd0);
    chk("rst_done", 32'(bus.instr_done), 32'd0);

    // lw: 0,1,2,3,4,0
    Res = 1'b0;
    bus.OP = 6'b100011;
    #1;
    chk("fetch_pc_en", 32'(bus.pc_en), 32'd1);
    chk("fetch_ir_wr", 32'(bus.IR_wr), 32'd1);
    chk("fetch_srcb", 32'(bus.alu_srcB), 32'd1);
    chk("fetch_alu", 32'(bus.Alucontrol), 32'd2);
    step("lw_decode", 4'd1);
    chk("dec_srcb", 32'(bus.alu_srcB), 32'd3);
    chk("dec_illegal", 32'(bus.illegal), 32'd0);
    chk("dec_pc_en", 32'(bus.pc_en), 32'd0);
    step("lw_memadr", 4'd2);
    chk("memadr_srca", 32'(bus.alu_srcA), 32'd1);
    chk("memadr_srcb", 32'(bus.alu_srcB), 32'd2);
    step("lw_memrd", 4'd3);
    chk("memrd_iord", 32'(bus.IorD), 32'd1);
    chk("memrd_reg_wr", 32'(bus.reg_wr), 32'd0);
    step("lw_memwb", 4'd4);
    chk("memwb_reg_wr", 32'(bus.reg_wr), 32'd1);
    chk("memwb_mem2reg", 32'(bus.mem2reg), 32'd1);
    chk("memwb_done", 32'(bus.instr_done), 32'd1);
    step("lw_end", 4'd0);
    chk("lw_end_done", 32'(bus.instr_done), 32'd0);

    // R-type slt
    bus.OP = 6'b000000;
    bus.Funct = 6'b101010;
    step("slt_decode", 4'd1);
    step("slt_exec", 4'd6);
    chk("slt_alu", 32'(bus.Alucontrol), 32'd7);
    chk("slt_srcb", 32'(bus.alu_srcB), 32'd0);
    step("slt_aluwb", 4'd7);
    chk("aluwb_reg_dst", 32'(bus.reg_dst), 32'd1);
    chk("aluwb_reg_wr", 32'(bus.reg_wr), 32'd1);
    step("slt_end", 4'd0);

    // R-type sub
    bus.Funct = 6'b100010;
    step("sub_decode", 4'd1);
    step("sub_exec", 4'd6);
    chk("sub_alu", 32'(bus.Alucontrol), 32'd6);
    step("sub_aluwb", 4'd7);
    step("sub_end", 4'd0);

    // beq taken, then Zero_Flag drop seen combinationally
    bus.OP = 6'b000100;
    bus.Zero_Flag = 1'b1;
    step("beq1_decode", 4'd1);
    step("beq1_branch", 4'd8);
    chk("beq1_pc_en", 32'(bus.pc_en), 32'd1);
    chk("beq1_pc_src", 32'(bus.PC_src), 32'd1);
    chk("beq1_alu", 32'(bus.Alucontrol), 32'd6);
    chk("beq1_done", 32'(bus.instr_done), 32'd1);
    bus.Zero_Flag = 1'b0;
    #1;
    chk("beq_zf_drop", 32'(bus.pc_en), 32'd0);
    step("beq1_end", 4'd0);

    // beq not taken
    step("beq0_decode", 4'd1);
    step("beq0_branch", 4'd8);
    chk("beq0_pc_en", 32'(bus.pc_en), 32'd0);
    step("beq0_end", 4'd0);

    // sw
    bus.OP = 6'b101011;
    step("sw_decode", 4'd1);
    step("sw_memadr", 4'd2);
    step("sw_memwr", 4'd5);
    chk("sw_mem_wr", 32'(bus.mem_wr), 32'd1);
    chk("sw_iord", 32'(bus.IorD), 32'd1);
    chk("sw_reg_wr", 32'(bus.reg_wr), 32'd0);
    step("sw_end", 4'd0);

    // j
    bus.OP = 6'b000010;
    step("j_decode", 4'd1);
    step("j_jump", 4'd11);
    chk("j_pc_src", 32'(bus.PC_src), 32'd2);
    chk("j_pc_en", 32'(bus.pc_en), 32'd1);
    step("j_end", 4'd0);

    // addi
    bus.OP = 6'b001000;
    step("addi_decode", 4'd1);
    step("addi_ex", 4'd9);
    chk("addi_srcb", 32'(bus.alu_srcB), 32'd2);
    step("addi_wb", 4'd10);
    chk("addi_reg_wr", 32'(bus.reg_wr), 32'd1);
    chk("addi_reg_dst", 32'(bus.reg_dst), 32'd0);
    step("addi_end", 4'd0);

    // illegal opcode
    bus.OP = 6'b111111;
    step("ill_decode", 4'd1);
    chk("ill_pulse", 32'(bus.illegal), 32'd1);
    chk("ill_wr", 32'({bus.reg_wr, bus.mem_wr}), 32'd0);
    step("ill_end", 4'd0);
    chk("ill_clear", 32'(bus.illegal), 32'd0);

    // reset asserted in MEMRD aborts the load
    bus.OP = 6'b100011;
    step("abort_decode", 4'd1);
    step("abort_memadr", 4'd2);
    step("abort_memrd", 4'd3);
    Res = 1'b1;
    step("abort_state", 4'd0);
    chk("abort_reg_wr", 32'(bus.reg_wr), 32'd0);
    chk("abort_ir_wr", 32'(bus.IR_wr), 32'd0);
    Res = 1'b0;
    #1;
    chk("restart_pc_en", 32'(bus.pc_en), 32'd1);
    chk("restart_ir_wr", 32'(bus.IR_wr), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
